// File: rtl/matrix_scan_bcm.sv
// matrix_scan_bcm: HUB75 row/bit-plane BCM scan sequencer; define MATRIX_SCAN_GHOST_BLANK_EN for OE blanking after row changes
module matrix_scan_bcm #(
  parameter int COLUMNS = 64,
  parameter int ROW_ADDR_BITS = 4,
  parameter int BIT_DEPTH = 6,
  parameter int OE_BASE = 23,
  parameter int OVERLAP = 67,
  parameter int LATCH_WIDTH = 1
`ifdef MATRIX_SCAN_GHOST_BLANK_EN
  , parameter int GHOST_BLANK = 4
`endif
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       pixel_ready,
  input  logic [7:0]                 global_brightness,
  output logic [$clog2(COLUMNS)-1:0] column_address,
  output logic                       pixel_shift,
  output logic [ROW_ADDR_BITS-1:0]   row_address,
  output logic [ROW_ADDR_BITS-1:0]   row_address_active,
  output logic [BIT_DEPTH-1:0]       brightness_mask,
  output logic [BIT_DEPTH-1:0]       brightness_mask_active,
  output logic                       row_latch,
  output logic                       output_enable,
  output logic                       frame_start
);
  localparam int CW = $clog2(COLUMNS);
  localparam int OW = $clog2((OE_BASE << (BIT_DEPTH - 1)) + 1);
  localparam int PW = OW + 9;
  localparam int IW = BIT_DEPTH > 1 ? $clog2(BIT_DEPTH) : 1;
  localparam int LW = $clog2(LATCH_WIDTH + 1);
  localparam logic [BIT_DEPTH-1:0] MSB = BIT_DEPTH'(1) << (BIT_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH_WAIT, LATCH} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            col_q, col_d;
  logic [ROW_ADDR_BITS-1:0] row_q, row_d, row_act_q, row_act_d;
  logic [BIT_DEPTH-1:0]     mask_q, mask_d, mask_act_q, mask_act_d;
  logic [LW-1:0]            lat_q, lat_d;
  logic                     oe_q, oe_d, fs_q, fs_d;
  logic [OW-1:0]            oe_cnt_q, oe_cnt_d, oe_len_q, oe_len_d;
  logic [BIT_DEPTH-1:0]     sel_mask;
  logic [IW-1:0]            idx;
  logic [OW-1:0]            len, scaled;
  logic [PW-1:0]            prod, q8;
  logic                     last_lat, busy, advance, start_oe;

  assign last_lat = state_q == LATCH && lat_q == LW'(LATCH_WIDTH - 1);
  assign advance  = !oe_q || int'(oe_cnt_q) >= OVERLAP;

`ifdef MATRIX_SCAN_GHOST_BLANK_EN
  localparam int GW = $clog2(GHOST_BLANK + 2);
  logic [GW-1:0] blank_q, blank_d;
  logic          row_change;
  assign row_change = last_lat && row_q != row_act_q && GHOST_BLANK > 0;
  assign busy       = oe_q || blank_q != '0;
  assign start_oe   = (last_lat && !row_change) || blank_q == GW'(1);
  always_comb blank_d = row_change ? GW'(GHOST_BLANK) : blank_q != '0 ? blank_q - 1'b1 : blank_q;
`else
  assign busy     = oe_q;
  assign start_oe = last_lat;
`endif

  // OE length is computed for the plane being lit, which is still in mask_q on the latch edge
  always_comb begin
    sel_mask = last_lat ? mask_q : mask_act_q;
    idx = '0;
    for (int i = 0; i < BIT_DEPTH; i++) if (sel_mask[i]) idx = IW'(i);
    len = OW'(OE_BASE) << idx;
    prod = PW'(len) * PW'({1'b0, global_brightness} + 9'd1);
    q8 = prod >> 8;
    scaled = q8 == '0 ? OW'(1) : OW'(q8);
  end

  always_comb begin
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    row_act_d = row_act_q;
    mask_d = mask_q;
    mask_act_d = mask_act_q;
    lat_d = lat_q;
    fs_d = 1'b0;
    oe_d = oe_q && oe_cnt_q != oe_len_q - 1'b1;
    oe_cnt_d = oe_q ? oe_cnt_q + 1'b1 : oe_cnt_q;
    oe_len_d = oe_len_q;
    case (state_q)
      IDLE: if (advance) begin
        state_d = SHIFT;
        col_d = CW'(COLUMNS - 1);
        fs_d = row_q == '0 && mask_q == MSB;
      end
      SHIFT: if (pixel_ready) begin
        col_d = col_q - 1'b1;
        state_d = col_q == '0 ? LATCH_WAIT : SHIFT;
      end
      LATCH_WAIT: if (!busy) begin
        state_d = LATCH;
        lat_d = '0;
      end
      default: begin
        lat_d = lat_q + 1'b1;
        if (last_lat) begin
          state_d = IDLE;
          mask_act_d = mask_q;
          row_act_d = row_q;
          mask_d = (mask_q[0] || mask_q == '0) ? MSB : mask_q >> 1;
          row_d = (mask_q[0] || mask_q == '0) ? row_q + 1'b1 : row_q;
        end
      end
    endcase
    if (start_oe) begin
      oe_d = 1'b1;
      oe_cnt_d = '0;
      oe_len_d = scaled;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
      col_q <= CW'(COLUMNS - 1);
      row_q <= '0;
      row_act_q <= '0;
      mask_q <= MSB;
      mask_act_q <= '0;
      lat_q <= '0;
      oe_q <= 1'b0;
      fs_q <= 1'b0;
      oe_cnt_q <= '0;
      oe_len_q <= '0;
`ifdef MATRIX_SCAN_GHOST_BLANK_EN
      blank_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      row_act_q <= row_act_d;
      mask_q <= mask_d;
      mask_act_q <= mask_act_d;
      lat_q <= lat_d;
      oe_q <= oe_d;
      fs_q <= fs_d;
      oe_cnt_q <= oe_cnt_d;
      oe_len_q <= oe_len_d;
`ifdef MATRIX_SCAN_GHOST_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  // strobes are gated by reset so a mid-pulse reset blanks the panel immediately
  assign column_address         = col_q;
  assign pixel_shift            = state_q == SHIFT && pixel_ready && !reset;
  assign row_address            = row_q;
  assign row_address_active     = row_act_q;
  assign brightness_mask        = mask_q;
  assign brightness_mask_active = mask_act_q;
  assign row_latch              = state_q == LATCH && !reset;
  assign output_enable          = oe_q && !reset;
  assign frame_start            = fs_q && !reset;
endmodule

// File: tb/tb_matrix_scan_bcm.sv
// tb_matrix_scan_bcm: randomized scoreboard bench for matrix_scan_bcm
module tb_matrix_scan_bcm;
  localparam int C = 8, RB = 2, BD = 6, OB = 23, OV = 67, LWID = 2;
  localparam int R = 1 << RB, STEPS = R * BD, NSTEPS = 3 * STEPS;
`ifdef MATRIX_SCAN_GHOST_BLANK_EN
  localparam int GAP = 4;
`else
  localparam int GAP = 0;
`endif

  typedef struct {int row; int mask; int len; int gap;} exp_t;

  logic clk = 0, reset, pixel_ready;
  logic [7:0] global_brightness;
  logic [$clog2(C)-1:0] column_address;
  logic pixel_shift, row_latch, output_enable, frame_start;
  logic [RB-1:0] row_address, row_address_active;
  logic [BD-1:0] brightness_mask, brightness_mask_active;

  int total = 0, bad = 0, fs_n = 0, s = 0, ecol = C - 1, mon_ph = 0, pr_mode = 0;
  bit mon_en = 0;
  exp_t q[$];

  matrix_scan_bcm #(.COLUMNS(C), .ROW_ADDR_BITS(RB), .BIT_DEPTH(BD), .OE_BASE(OB),
                    .OVERLAP(OV), .LATCH_WIDTH(LWID)) dut (
    .clk_in(clk), .reset(reset), .pixel_ready(pixel_ready),
    .global_brightness(global_brightness), .column_address(column_address),
    .pixel_shift(pixel_shift), .row_address(row_address),
    .row_address_active(row_address_active), .brightness_mask(brightness_mask),
    .brightness_mask_active(brightness_mask_active), .row_latch(row_latch),
    .output_enable(output_enable), .frame_start(frame_start));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: bound expired", nm);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_col"}, column_address, C - 1);
    chk({tag, "_mask"}, brightness_mask, 1 << (BD - 1));
    chk({tag, "_mask_act"}, brightness_mask_active, 0);
    chk({tag, "_row"}, row_address, 0);
    chk({tag, "_row_act"}, row_address_active, 0);
    chk({tag, "_shift"}, pixel_shift, 0);
    chk({tag, "_latch"}, row_latch, 0);
    chk({tag, "_oe"}, output_enable, 0);
    chk({tag, "_fs"}, frame_start, 0);
  endtask

  task automatic wait_latch(output bit ok);
    int c = 0;
    while (row_latch && c < 5000) begin @(negedge clk); c++; end
    while (!row_latch && c < 5000) begin
      @(negedge clk);
      c++;
      if (output_enable) global_brightness = 8'($urandom);
    end
    ok = row_latch;
  endtask

  initial begin
    pixel_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      pixel_ready = pr_mode == 0 ? 1'b1 : pr_mode == 1 ? ~pixel_ready : 1'($urandom);
    end
  end

  // monitor: checks shift sequence and each latch/OE pulse against the scoreboard
  initial begin
    int lat_n, gap, oe_n;
    exp_t e;
    lat_n = 0; gap = 0; oe_n = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        mon_ph = 0; lat_n = 0; s = 0; ecol = C - 1;
        continue;
      end
      if (frame_start) begin
        fs_n++;
        chk("frame_start_pos", int'(s % STEPS == 0 && ecol == C - 1), 1);
      end
      if (pixel_shift) begin
        chk("shift_col", column_address, ecol);
        chk("shift_row", row_address, (s / BD) % R);
        chk("shift_mask", brightness_mask, 1 << (BD - 1 - s % BD));
        if (ecol == 0) begin s++; ecol = C - 1; end
        else ecol--;
      end
      if (row_latch) begin
        chk("latch_oe_overlap", output_enable, 0);
        lat_n++;
        mon_ph = 1;
      end else begin
        if (mon_ph == 1) begin
          chk("latch_width", lat_n, LWID);
          lat_n = 0;
          if (q.size() == 0) begin
            fail("scoreboard_empty");
            mon_ph = 0;
          end else begin
            e = q.pop_front();
            chk("row_active", row_address_active, e.row);
            chk("mask_active", brightness_mask_active, e.mask);
            gap = 0; oe_n = 0; mon_ph = 2;
          end
        end
        if (mon_ph == 2) begin
          if (output_enable) begin oe_n = 1; mon_ph = 3; end
          else if (++gap > 1000) begin fail("oe_start"); mon_ph = 0; end
        end else if (mon_ph == 3) begin
          if (output_enable) oe_n++;
          else begin
            chk("oe_gap", gap, e.gap);
            chk("oe_len", oe_n, e.len);
            mon_ph = 0;
          end
        end
      end
    end
  end

  initial begin
    bit ok;
    int b, plane, row, f, c;
    exp_t e;
    reset = 1;
    global_brightness = 8'd255;
    repeat (3) @(posedge clk);
    #1;
    reset_vals("reset");
    @(negedge clk);
    reset = 0;
    mon_en = 1;
    for (int k = 0; k < NSTEPS; k++) begin
      wait_latch(ok);
      if (!ok) begin fail("latch_wait"); break; end
      f = k / STEPS;
      plane = BD - 1 - k % BD;
      row = (k / BD) % R;
      b = f == 0 ? 255 : (f == 1 && plane == 0) ? ((k / BD) % 2 ? 0 : 127) : int'($urandom_range(0, 255));
      global_brightness = 8'(b);
      e.row = row;
      e.mask = 1 << plane;
      e.len = ((OB << plane) * (b + 1)) / 256;
      if (e.len < 1) e.len = 1;
      e.gap = (k > 0 && row != ((k - 1) / BD) % R) ? GAP : 0;
      q.push_back(e);
      pr_mode = (k + 1) / STEPS;
    end
    chk("frame_start_count", fs_n, NSTEPS / STEPS);
    c = 0;
    while ((q.size() != 0 || mon_ph != 0) && c < 5000) begin @(negedge clk); c++; end
    if (c >= 5000) fail("drain");
    pr_mode = 0;
    mon_en = 0;
    c = 0;
    while (!output_enable && c < 5000) begin @(negedge clk); c++; end
    if (!output_enable) fail("oe_wait");
    reset = 1;
    #1;
    chk("rst_oe_same_cycle", output_enable, 0);
    @(posedge clk);
    #1;
    reset_vals("oe_reset");
    @(negedge clk);
    reset = 0;
    c = 0;
    while (!(pixel_shift && column_address == 4) && c < 100) begin @(negedge clk); c++; end
    if (c >= 100) fail("shift_wait");
    reset = 1;
    #1;
    chk("rst_shift_same_cycle", pixel_shift, 0);
    @(posedge clk);
    #1;
    reset_vals("shift_reset");
    @(negedge clk);
    reset = 0;
    c = 0;
    while (!frame_start && c < 10) begin @(negedge clk); c++; end
    chk("restart_frame_start", frame_start, 1);
    chk("restart_col", column_address, C - 1);
    chk("restart_shift", pixel_shift, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/matrix_scan_bcm.md
Name: matrix_scan_bcm

Overview:
- Parametrised successor to the HUB75 row/bit-plane scanner; drives column shift, row latch, row address and binary-coded-modulation output enable for panels of any width, row count and colour depth.
- Sits between the framebuffer read port and the panel pin driver; generates clock *enables* only, so everything runs in the single clk_in domain.
- Adds a framebuffer stall handshake, a global brightness scaler and a frame-start marker.

Parameters:
- COLUMNS, 64, pixels shifted per row; must be ≥ 2.
- ROW_ADDR_BITS, 4, row address width; rows = 2**ROW_ADDR_BITS.
- BIT_DEPTH, 6, bit-planes per sub-pixel; must be ≥ 1.
- OE_BASE, 23, OE cycles for the LSB plane; plane b lasts OE_BASE<<b.
- OVERLAP, 67, elapsed OE cycles after which the next shift may begin.
- LATCH_WIDTH, 1, row_latch high time in cycles; must be ≥ 1.

Ports:
- clk_in  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- pixel_ready  input  1  framebuffer has data for column_address; low stalls the shift.
- global_brightness  input  8  OE scale; 255 = full length.
- column_address  output  clog2(COLUMNS)  column being shifted; counts COLUMNS-1 down to 0.
- pixel_shift  output  1  one-cycle enable: shift the data for column_address this cycle.
- row_address  output  ROW_ADDR_BITS  row being shifted.
- row_address_active  output  ROW_ADDR_BITS  row currently lit.
- brightness_mask  output  BIT_DEPTH  one-hot plane being shifted.
- brightness_mask_active  output  BIT_DEPTH  one-hot plane currently lit; 0 = none.
- row_latch  output  1  latch strobe.
- output_enable  output  1  LEDs on, active-high.
- frame_start  output  1  one-cycle pulse when row 0 / MSB plane begins shifting.

Behaviour:
- Reset (synchronous): all outputs 0, except brightness_mask = MSB one-hot and column_address = COLUMNS-1. FSM enters IDLE and OE timer stops.
- FSM has four states: IDLE, SHIFT, LATCH_WAIT, LATCH.
- IDLE → SHIFT when the advance condition holds.
  - Advance condition: output_enable == 0, or OE elapsed count ≥ OVERLAP.
  - Advance is true on the first cycle after reset.
- On every entry to SHIFT, column_address is loaded with COLUMNS-1.
- In SHIFT:
  - pixel_shift = pixel_ready.
  - column_address decrements on each cycle with pixel_shift set.
  - After the column-0 shift, go to LATCH_WAIT.
  - pixel_ready low freezes column_address, and no shift occurs that cycle.
- LATCH_WAIT holds until output_enable == 0. The next state is LATCH, which must never overlap OE.
- LATCH: row_latch is high for exactly LATCH_WIDTH cycles. On the last latch cycle:
  - brightness_mask_active ← brightness_mask and row_address_active ← row_address.
  - brightness_mask shifts right. From LSB (or 0) it reloads MSB and row_address increments, wrapping from 2**ROW_ADDR_BITS-1 to 0.
  - The FSM returns to IDLE.
- OE timer starts the cycle after LATCH ends.
  - len = OE_BASE << index(brightness_mask_active).
  - scaled = (len*(global_brightness+1)) >> 8, floored at 1.
  - output_enable is high for exactly `scaled` cycles.
  - global_brightness is sampled at OE start and ignored mid-pulse.
- Arithmetic widths: the OE counter is wide enough for OE_BASE<<(BIT_DEPTH-1), and the product uses that width plus 9 bits, with no truncation.
- frame_start pulses on the cycle SHIFT is entered with row_address == 0 and the MSB plane selected, including the first entry after reset.
- Reset mid-shift or mid-OE: reset wins the same cycle; output_enable and row_latch drop that cycle.

Optional Feature:
- Macro: MATRIX_SCAN_GHOST_BLANK_EN.
- When defined, the OE start is delayed after a latch that changed row_address_active. A parameter GHOST_BLANK (default 4) adds that many cycles with output_enable held low, to suppress ghosting.
- The delay is not applied on plane-only changes.
- When undefined, OE starts immediately after LATCH as specified above.

Test Plan:
- COLUMNS=8, pixel_ready=1 after reset → 8 pixel_shift pulses with column_address 7..0, then row_latch 1 cycle, then output_enable 736 cycles (MSB, brightness 255); frame_start once.
- Defaults with pixel_ready toggling 0/1 every cycle → 64 shifts over 128 cycles, no column skipped or repeated.
- Full scan → brightness_mask_active cycles through 100000..000001 with OE lengths 736/368/184/92/46/23; row increments after LSB; row 15→0 wraps and frame_start pulses.
- global_brightness=127, LSB plane → OE = (23*128)>>8 = 11 cycles; global_brightness=0 → 1 cycle minimum.
- Assert reset during SHIFT at column 30 → next cycle all outputs at reset values; restart shows frame_start and column 63.
- MATRIX_SCAN_GHOST_BLANK_EN defined → 4 low cycles between row_latch end and OE only on row change; none between planes.
